// File: rtl/conv_cfg_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : conv_cfg_loader_pkg                                             |
// | Purpose  : Shared field widths, bank/error encodings, FSM states and the   |
// |            bytes-per-entry helper for the conv config loader.              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package conv_cfg_loader_pkg;

  localparam int BW       = 8;   // weight element / stream byte width
  localparam int BIAS_BW  = 32;  // bias field width
  localparam int SHIFT_BW = 5;   // shift field width

  localparam logic [2:0] BANK_W0    = 3'd0;
  localparam logic [2:0] BANK_W1    = 3'd1;
  localparam logic [2:0] BANK_W2    = 3'd2;
  localparam logic [2:0] BANK_BIAS  = 3'd3;
  localparam logic [2:0] BANK_SHIFT = 3'd4;

  localparam logic [1:0] ERR_OK           = 2'd0;
  localparam logic [1:0] ERR_EARLY_LAST   = 2'd1;
  localparam logic [1:0] ERR_MISSING_LAST = 2'd2;
  localparam logic [1:0] ERR_VERIFY       = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_VRD   = 3'd3,
    ST_VWAIT = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Number of stream bytes that make up one entry of the given bank.
  function automatic int bytes_per_bank(input logic [2:0] bank, input int vl);
    case (bank)
      BANK_BIAS:  bytes_per_bank = BIAS_BW / BW;
      BANK_SHIFT: bytes_per_bank = 1;
      default:    bytes_per_bank = vl;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_cfg_loader_cfg_byte_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cfg_byte_packer                                                 |
// | Purpose  : Little-endian byte-to-entry packer. Counts bytes of the current |
// |            entry and flags the entry's final byte.                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cfg_byte_packer
  import conv_cfg_loader_pkg::*;
#(
  parameter int VECTOR_LEN = 13,
  parameter int CW         = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     accept,
  input  logic [BW-1:0]            byte_in,
  input  logic [CW-1:0]            entry_len,
  output logic                     entry_done,
  output logic [VECTOR_LEN*BW-1:0] entry_data
);

  logic [CW-1:0]            count;
  logic [VECTOR_LEN*BW-1:0] nxt;

  assign entry_done = accept && (count == entry_len - 1'b1);

  // Next packed value: first byte of an entry zeroes the upper (unused) lanes.
  always_comb begin
    nxt = (count == '0) ? '0 : entry_data;
    for (int k = 0; k < VECTOR_LEN; k++) begin
      if (count == CW'(k)) nxt[k*BW +: BW] = byte_in;
    end
  end

  // Byte counter and shift-in register; counter restarts after each entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      entry_data <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (accept) begin
      entry_data <= nxt;
      count      <= entry_done ? '0 : count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_cfg_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : conv_cfg_loader                                                 |
// | Purpose  : Streams a host byte image into the conv layer parameter banks   |
// |            in bank-major order, with an optional checksum read-back pass.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module conv_cfg_loader
  import conv_cfg_loader_pkg::*;
#(
  parameter int VECTOR_LEN  = 13,
  parameter int NUM_FILTERS = 8,
  parameter int RD_LATENCY  = 1,
  localparam int AW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int DW = VECTOR_LEN * BW
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic          verify_i,
  input  logic [7:0]    data_i,
  input  logic          valid_i,
  input  logic          last_i,
  output logic          ready_o,
  output logic          rd_en_o,
  output logic          wr_en_o,
  output logic [2:0]    rd_wr_bank_o,
  output logic [AW-1:0] rd_wr_addr_o,
  output logic [DW-1:0] wr_data_o,
  input  logic [DW-1:0] rd_data_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [1:0]    err_o
);

  localparam int CW = $clog2(VECTOR_LEN + 1);
  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  state_t        state;
  logic [2:0]    bank;
  logic [AW-1:0] addr;
  logic          ready, wr_en, rd_en, busy, done;
  logic [1:0]    err;
  logic          verify_q, missing_last;
  logic [15:0]   wsum, rsum;
  logic [LW-1:0] lat_cnt;

  logic          accept, start_acc, entry_done, last_addr, last_entry;
  logic [BW-1:0] byte_m;
  logic [CW-1:0] entry_len;
  logic [15:0]   rd_sum, sum_acc;

  assign accept     = valid_i && ready;
  assign start_acc  = (state == ST_IDLE) && start_i;
  assign byte_m     = (bank == BANK_SHIFT) ? {{(BW-SHIFT_BW){1'b0}}, data_i[SHIFT_BW-1:0]} : data_i;
  assign entry_len  = CW'(bytes_per_bank(bank, VECTOR_LEN));
  assign last_addr  = (addr == AW'(NUM_FILTERS - 1));
  assign last_entry = last_addr && (bank == BANK_SHIFT);
  assign sum_acc    = rsum + rd_sum;

  cfg_byte_packer #(
    .VECTOR_LEN (VECTOR_LEN),
    .CW         (CW)
  ) u_packer (
    .clk        (clk_i),
    .rst_n      (rst_n_i),
    .clear      (start_acc),
    .accept     (accept),
    .byte_in    (byte_m),
    .entry_len  (entry_len),
    .entry_done (entry_done),
    .entry_data (wr_data_o)
  );

  // Byte sum of the field returned by a read; shift lane masked like on write.
  always_comb begin
    rd_sum = '0;
    for (int k = 0; k < VECTOR_LEN; k++) begin
      if (CW'(k) < entry_len) rd_sum = rd_sum + 16'(rd_data_i[k*BW +: BW]);
    end
    if (bank == BANK_SHIFT) rd_sum = 16'(rd_data_i[SHIFT_BW-1:0]);
  end

  // Control FSM with registered strobes, counters and checksum accumulators.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= ST_IDLE;
      bank         <= '0;
      addr         <= '0;
      ready        <= 1'b0;
      wr_en        <= 1'b0;
      rd_en        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= ERR_OK;
      verify_q     <= 1'b0;
      missing_last <= 1'b0;
      wsum         <= '0;
      rsum         <= '0;
      lat_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state        <= ST_LOAD;
            ready        <= 1'b1;
            busy         <= 1'b1;
            err          <= ERR_OK;
            verify_q     <= verify_i;
            missing_last <= 1'b0;
            wsum         <= '0;
            rsum         <= '0;
            bank         <= '0;
            addr         <= '0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            wsum <= wsum + 16'(byte_m);
            if (last_i && !(last_entry && entry_done)) begin
              // Image ended too early: drop the partial entry and finish.
              ready <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              err   <= ERR_EARLY_LAST;
              bank  <= '0;
              addr  <= '0;
              state <= ST_DONE;
            end else if (entry_done) begin
              ready        <= 1'b0;
              wr_en        <= 1'b1;
              missing_last <= last_entry && !last_i;
              state        <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          wr_en <= 1'b0;
          if (last_entry) begin
            bank <= '0;
            addr <= '0;
            if (verify_q && !missing_last) begin
              rd_en <= 1'b1;
              state <= ST_VRD;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              err   <= missing_last ? ERR_MISSING_LAST : ERR_OK;
              state <= ST_DONE;
            end
          end else begin
            if (last_addr) begin
              addr <= '0;
              bank <= bank + 3'd1;
            end else begin
              addr <= addr + 1'b1;
            end
            ready <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_VRD: begin
          rd_en   <= 1'b0;
          lat_cnt <= LW'(RD_LATENCY - 1);
          state   <= ST_VWAIT;
        end
        ST_VWAIT: begin
          if (lat_cnt == '0) begin
            rsum <= sum_acc;
            if (last_entry) begin
              bank  <= '0;
              addr  <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              err   <= (sum_acc == wsum) ? ERR_OK : ERR_VERIFY;
              state <= ST_DONE;
            end else begin
              if (last_addr) begin
                addr <= '0;
                bank <= bank + 3'd1;
              end else begin
                addr <= addr + 1'b1;
              end
              rd_en <= 1'b1;
              state <= ST_VRD;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ready_o      = ready;
  assign rd_en_o      = rd_en;
  assign wr_en_o      = wr_en;
  assign rd_wr_bank_o = bank;
  assign rd_wr_addr_o = addr;
  assign busy_o       = busy;
  assign done_o       = done;
  assign err_o        = err;

endmodule
`default_nettype wire
